// File: rtl/down_timer_if.sv
// ============================================================================
// Module      : down_timer_if
// Description : Control/status bundle between a controller (game FSM) and the
//               down_timer block. The controller drives load/start/pause/abort;
//               the timer returns count/busy/done/expired.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface down_timer_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic                  load;
  logic [DATA_WIDTH-1:0] load_value;
  logic                  start;
  logic                  pause;
  logic                  abort;
  logic [DATA_WIDTH-1:0] count;
  logic                  busy;
  logic                  done;
  logic                  expired;

  // Controller side
  modport master (
    output load, load_value, start, pause, abort,
    input  count, busy, done, expired
  );

  // Timer side
  modport slave (
    input  load, load_value, start, pause, abort,
    output count, busy, done, expired
  );

endinterface

`default_nettype wire

// File: rtl/down_timer.sv
// ============================================================================
// Module      : down_timer
// Description : Loadable down-counting timer with start/pause/abort control,
//               a sticky done flag and a one-cycle expiry pulse. The count
//               decrements once every PRESCALE running cycles.
//               Optional feature macro: AUTO_RELOAD_EN - on expiry the count
//               is reloaded from the last accepted load value and the timer
//               keeps running instead of stopping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module down_timer #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 4
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  down_timer_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSED  = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_count;
  logic [DATA_WIDTH-1:0] w_count_nxt;
  logic [DATA_WIDTH-1:0] w_eff_value;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_expired;
  logic                  w_expired_nxt;
  logic                  w_presc_clr;
  logic                  w_presc_adv;
  logic                  w_tick;

`ifdef AUTO_RELOAD_EN
  logic [DATA_WIDTH-1:0] r_reload;

  // Remember the last accepted load value as the auto-reload period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reload <= '0;
    end else if (!bus.abort && bus.load &&
                 (r_state == S_IDLE || r_state == S_EXPIRED)) begin
      r_reload <= bus.load_value;
    end
  end
`endif

  // Prescaler: w_tick marks the running cycle on which the count decrements
  generate
    if (PRESCALE > 1) begin : g_presc
      localparam int c_PRESC_W = $clog2(PRESCALE);
      logic [c_PRESC_W-1:0] r_presc;

      // Phase counter 0..PRESCALE-1, frozen unless the timer is advancing
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_presc <= '0;
        end else if (w_presc_clr) begin
          r_presc <= '0;
        end else if (w_presc_adv) begin
          r_presc <= w_tick ? '0 : r_presc + 1'b1;
        end
      end

      assign w_tick = (r_presc == c_PRESC_W'(PRESCALE - 1));
    end else begin : g_no_presc
      logic w_unused_presc;
      assign w_unused_presc = w_presc_clr | w_presc_adv;
      assign w_tick         = 1'b1;
    end
  endgenerate

  // A start coinciding with a load uses the freshly loaded value
  assign w_eff_value = bus.load ? bus.load_value : r_count;

  // Next-state, next-count and expiry decisions in priority order
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_expired_nxt = 1'b0;
    w_presc_clr   = 1'b0;
    w_presc_adv   = 1'b0;

    if (bus.abort) begin
      w_state_nxt = S_IDLE;
      w_count_nxt = '0;
      w_presc_clr = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.load) begin
            w_count_nxt = bus.load_value;
          end
          if (bus.start) begin
            if (w_eff_value != '0) begin
              w_state_nxt = S_RUN;
              w_presc_clr = 1'b1;
            end else begin
              w_state_nxt   = S_EXPIRED;
              w_expired_nxt = 1'b1;
            end
          end
        end

        S_EXPIRED: begin
          if (bus.load) begin
            w_count_nxt = bus.load_value;
            w_state_nxt = S_IDLE;
          end
        end

        // Leaving PAUSED counts as a running cycle so no time is lost
        S_RUN, S_PAUSED: begin
          if (bus.pause) begin
            w_state_nxt = S_PAUSED;
          end else begin
            w_state_nxt = S_RUN;
            w_presc_adv = 1'b1;
            if (w_tick) begin
              if (r_count <= DATA_WIDTH'(1)) begin
                w_expired_nxt = 1'b1;
`ifdef AUTO_RELOAD_EN
                if (r_reload != '0) begin
                  w_count_nxt = r_reload;
                end else begin
                  w_count_nxt = '0;
                  w_state_nxt = S_EXPIRED;
                end
`else
                w_count_nxt = '0;
                w_state_nxt = S_EXPIRED;
`endif
              end else begin
                w_count_nxt = r_count - 1'b1;
              end
            end
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered outputs, derived from the upcoming state so they align with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_count   <= w_count_nxt;
      r_busy    <= (w_state_nxt == S_RUN) || (w_state_nxt == S_PAUSED);
      r_done    <= (w_state_nxt == S_EXPIRED);
      r_expired <= w_expired_nxt;
    end
  end

  assign bus.count   = r_count;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.expired = r_expired;

endmodule

`default_nettype wire

// File: tb/tb_down_timer.sv
// ============================================================================
// Module      : tb_down_timer
// Description : Self-checking bench for down_timer. Two instances (PRESCALE 4
//               and 1) receive identical stimulus and are compared each cycle
//               against a remaining-cycle-budget reference model.
//               Honours AUTO_RELOAD_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_down_timer;

  localparam int DW     = 8;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_PAUS = 2;
  localparam int M_EXP  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  logic          ld;
  logic [DW-1:0] lv;
  logic          st;
  logic          pa;
  logic          ab;

  down_timer_if #(.DATA_WIDTH(DW)) if4 ();
  down_timer_if #(.DATA_WIDTH(DW)) if1 ();

  assign if4.load = ld;  assign if4.load_value = lv;  assign if4.start = st;
  assign if4.pause = pa; assign if4.abort = ab;
  assign if1.load = ld;  assign if1.load_value = lv;  assign if1.start = st;
  assign if1.pause = pa; assign if1.abort = ab;

  down_timer #(.DATA_WIDTH(DW), .PRESCALE(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  down_timer #(.DATA_WIDTH(DW), .PRESCALE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model: state, visible count, remaining running cycles, reload
  int c_pre [2] = '{4, 1};
  int m_mode[2];
  int m_cnt [2];
  int m_tick[2];
  int m_rl  [2];
  int m_exp [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = M_IDLE; m_cnt[k] = 0; m_tick[k] = 0; m_rl[k] = 0; m_exp[k] = 0;
    end
  endtask

  // One clock edge of the specification's behaviour for instance k
  task automatic model_step(input int k);
    bit was_idle;
    m_exp[k] = 0;
    was_idle = (m_mode[k] == M_IDLE);
    if (ab) begin
      m_mode[k] = M_IDLE; m_cnt[k] = 0; m_tick[k] = 0;
    end else begin
      if (ld && (m_mode[k] == M_IDLE || m_mode[k] == M_EXP)) begin
        m_cnt[k] = lv; m_rl[k] = lv; m_mode[k] = M_IDLE;
      end
      if (st && was_idle) begin
        if (m_cnt[k] != 0) begin
          m_mode[k] = M_RUN;
          m_tick[k] = m_cnt[k] * c_pre[k];
        end else begin
          m_mode[k] = M_EXP; m_exp[k] = 1;
        end
      end else if (m_mode[k] == M_RUN || m_mode[k] == M_PAUS) begin
        if (pa) begin
          m_mode[k] = M_PAUS;
        end else begin
          m_mode[k] = M_RUN;
          m_tick[k]--;
          if (m_tick[k] == 0) begin
            m_exp[k] = 1;
`ifdef AUTO_RELOAD_EN
            if (m_rl[k] != 0) begin
              m_cnt[k] = m_rl[k]; m_tick[k] = m_rl[k] * c_pre[k];
            end else begin
              m_cnt[k] = 0; m_mode[k] = M_EXP;
            end
`else
            m_cnt[k] = 0; m_mode[k] = M_EXP;
`endif
          end else begin
            m_cnt[k] = (m_tick[k] + c_pre[k] - 1) / c_pre[k];
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      logic [DW-1:0] c;
      logic b, d, e;
      if (k == 0) begin
        c = if4.count; b = if4.busy; d = if4.done; e = if4.expired;
      end else begin
        c = if1.count; b = if1.busy; d = if1.done; e = if1.expired;
      end
      check($sformatf("P%0d count", c_pre[k]), c, m_cnt[k]);
      check($sformatf("P%0d busy", c_pre[k]), b, (m_mode[k] == M_RUN || m_mode[k] == M_PAUS));
      check($sformatf("P%0d done", c_pre[k]), d, (m_mode[k] == M_EXP));
      check($sformatf("P%0d expired", c_pre[k]), e, m_exp[k]);
    end
  endtask

  // Drive one cycle of inputs, clock it, advance the model, compare
  task automatic cycle(input bit l, input int v, input bit s, input bit p, input bit a);
    ld = l; lv = v[DW-1:0]; st = s; pa = p; ab = a;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k);
    cyc++;
    #1 check_outputs();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  initial begin
    int t_start;
    int t_exp4;
    int t_exp1;
    int n_pulse;
    bit pause_lvl;

    ld = 0; lv = '0; st = 0; pa = 0; ab = 0;
    model_reset();

    // Reset state
    #12;
    check("reset count", if4.count, 0);
    check("reset busy", if4.busy, 0);
    check("reset done", if4.done, 0);
    check("reset expired", if4.expired, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // load 3, start: decrements every 4 edges, expiry at +12 (P4) / +3 (P1)
    cycle(1, 3, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    t_start = cyc; t_exp4 = -1; t_exp1 = -1;
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 0, 0, 0);
      if (if4.expired && t_exp4 < 0) t_exp4 = cyc - t_start;
      if (if1.expired && t_exp1 < 0) t_exp1 = cyc - t_start;
    end
    check("P4 expiry latency", t_exp4, 12);
    check("P1 expiry latency", t_exp1, 3);

    // load+start same cycle, then start from a zero count
    cycle(1, 5, 1, 0, 0);
    check("P4 load+start count", if4.count, 5);
    cycle(0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    check("P4 zero start expired", if4.expired, 1);
    cycle(1, 0, 0, 0, 0);

    // Pause 6 cycles mid-period delays expiry by exactly 6
    cycle(1, 3, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    t_start = cyc; t_exp4 = -1;
    idle_cycles(5);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 0, 0, 0);
      if (if4.expired && t_exp4 < 0) t_exp4 = cyc - t_start;
    end
    check("P4 paused expiry latency", t_exp4, 18);
    cycle(1, 0, 0, 0, 0);

    // Load during RUN ignored, abort at count 2 clears without a pulse
    cycle(1, 5, 1, 0, 0);
    idle_cycles(11);
    cycle(1, 9, 0, 0, 0);
    check("P4 count before abort", if4.count, 2);
    cycle(0, 0, 0, 0, 1);
    check("P4 abort count", if4.count, 0);
    idle_cycles(30);

    // Asynchronous reset in the middle of a run
    cycle(1, 3, 1, 0, 0);
    idle_cycles(2);
    #3 rst_n = 1'b0;
    #1;
    check("async reset count", if4.count, 0);
    check("async reset busy", if4.busy, 0);
    check("async reset done", if4.done, 0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;

`ifdef AUTO_RELOAD_EN
    // Auto-reload: P1 with period 2 pulses every other cycle and stays busy
    cycle(1, 2, 1, 0, 0);
    n_pulse = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 0, 0);
      n_pulse += int'(if1.expired);
      check("P1 reload busy", if1.busy, 1);
    end
    check("P1 reload pulses", n_pulse, 5);
    cycle(0, 0, 0, 0, 1);
`endif

    // Randomised traffic against the model
    pause_lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(9) == 0) pause_lvl = ~pause_lvl;
      cycle(($urandom_range(5) == 0), int'($urandom_range(7)), ($urandom_range(3) == 0),
            pause_lvl, ($urandom_range(49) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Hard stop if the stimulus thread ever stalls
  initial begin
    #2000000;
    $display("FAIL timeout observed=%0d expected=%0d", cyc, 0);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
